// File: rtl/audio_ctrl_pkg.sv
// rtl/audio_ctrl_pkg.sv - shared types and defaults for the audio mode controller
package audio_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    REC_PAUSE  = 3'd2,
    PLAY       = 3'd3,
    PLAY_PAUSE = 3'd4
  } state_t;

  typedef logic signed [3:0] speed_t;

  localparam int MAX_SPEED_DEF = 7;

  typedef enum logic [1:0] {
    KEY_NONE = 2'd0,
    KEY_1    = 2'd1,
    KEY_0    = 2'd2,
    KEY_2    = 2'd3
  } key_sel_t;

  // One key event per cycle: key_1 beats key_0 beats key_2.
  function automatic key_sel_t pick_key(input logic k0, input logic k1, input logic k2);
    if (k1) begin
      return KEY_1;
    end else if (k0) begin
      return KEY_0;
    end else if (k2) begin
      return KEY_2;
    end else begin
      return KEY_NONE;
    end
  endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - input sampling chain with a registered edge pulse
// STAGES sets the sampling depth; ANY_EDGE selects toggle detection instead of rising-edge only.
module key_edge #(
  parameter int STAGES   = 1,
  parameter bit ANY_EDGE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic level_o,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   chain;
  logic              pulse_q;

  assign chain = {sync_q, in_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= chain[STAGES-1:0];
      pulse_q <= ANY_EDGE ? (chain[STAGES-1] ^ chain[STAGES])
                          : (chain[STAGES-1] & ~chain[STAGES]);
    end
  end

  assign level_o = chain[STAGES];
  assign pulse_o = pulse_q;

endmodule

// File: rtl/audio_mode_ctrl.sv
// rtl/audio_mode_ctrl.sv - record/playback sequencer: keys and mode switch to recorder/player commands
module audio_mode_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int MAX_SPEED = MAX_SPEED_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_0,
  input  logic              i_key_1,
  input  logic              i_key_2,
  input  logic              i_sw_0,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_rec_full,
  input  logic              i_play_done,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic              o_recording,
  output logic              o_playing,
  output logic [3:0]        o_speed_idx,
  output logic [ADDR_W-1:0] o_rec_len,
  output logic [2:0]        o_state
);

  localparam speed_t SPD_MAX = speed_t'(MAX_SPEED);
  localparam speed_t SPD_MIN = speed_t'(-MAX_SPEED);

  logic k0_p, k1_p, k2_p, k0_lvl, k1_lvl, k2_lvl;
  logic sw_lvl, sw_tog;
  logic unused_key_lvl;

  key_edge #(.STAGES(1), .ANY_EDGE(1'b0)) u_key0 (
    .clk_i(i_clk), .rst_i(i_rst), .in_i(i_key_0), .level_o(k0_lvl), .pulse_o(k0_p));
  key_edge #(.STAGES(1), .ANY_EDGE(1'b0)) u_key1 (
    .clk_i(i_clk), .rst_i(i_rst), .in_i(i_key_1), .level_o(k1_lvl), .pulse_o(k1_p));
  key_edge #(.STAGES(1), .ANY_EDGE(1'b0)) u_key2 (
    .clk_i(i_clk), .rst_i(i_rst), .in_i(i_key_2), .level_o(k2_lvl), .pulse_o(k2_p));
  key_edge #(.STAGES(2), .ANY_EDGE(1'b1)) u_sw (
    .clk_i(i_clk), .rst_i(i_rst), .in_i(i_sw_0), .level_o(sw_lvl), .pulse_o(sw_tog));

  assign unused_key_lvl = k0_lvl ^ k1_lvl ^ k2_lvl;

  state_t              state_q;
  speed_t              speed_q;
  logic [ADDR_W-1:0]   rec_len_q;
  logic                rec_start_q, rec_pause_q, rec_stop_q;
  logic                play_start_q, play_pause_q, play_stop_q;
  key_sel_t            key;
  logic                in_rec, in_play;

  assign key     = pick_key(k0_p, k1_p, k2_p);
  assign in_rec  = (state_q == REC) || (state_q == REC_PAUSE);
  assign in_play = (state_q == PLAY) || (state_q == PLAY_PAUSE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      speed_q      <= '0;
      rec_len_q    <= '0;
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      play_start_q <= 1'b0;
      play_pause_q <= 1'b0;
      play_stop_q  <= 1'b0;
    end else begin
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      play_start_q <= 1'b0;
      play_pause_q <= 1'b0;
      play_stop_q  <= 1'b0;
      // Forced stops (switch toggle, then end-of-media) outrank any key.
      if (in_rec && (sw_tog || (state_q == REC && i_rec_full) || key == KEY_0)) begin
        state_q    <= IDLE;
        rec_stop_q <= 1'b1;
        rec_len_q  <= i_rec_addr;
      end else if (in_play && (sw_tog || i_play_done || (state_q == PLAY && key == KEY_0))) begin
        state_q     <= IDLE;
        play_stop_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (key == KEY_1 && sw_lvl) begin
              state_q      <= PLAY;
              play_start_q <= 1'b1;
            end else if (key == KEY_1) begin
              state_q     <= REC;
              rec_start_q <= 1'b1;
            end else if (sw_lvl && key == KEY_0 && speed_q != SPD_MAX) begin
              speed_q <= speed_q + speed_t'(1);
            end else if (sw_lvl && key == KEY_2 && speed_q != SPD_MIN) begin
              speed_q <= speed_q - speed_t'(1);
            end
          end
          REC: begin
            if (key == KEY_1) begin
              state_q     <= REC_PAUSE;
              rec_pause_q <= 1'b1;
            end
          end
          REC_PAUSE: begin
            if (key == KEY_1) begin
              state_q     <= REC;
              rec_start_q <= 1'b1;
            end
          end
          PLAY: begin
            if (key == KEY_1) begin
              state_q      <= PLAY_PAUSE;
              play_pause_q <= 1'b1;
            end else if (key == KEY_2 && speed_q != SPD_MIN) begin
              speed_q <= speed_q - speed_t'(1);
            end
          end
          PLAY_PAUSE: begin
            if (key == KEY_1) begin
              state_q      <= PLAY;
              play_start_q <= 1'b1;
            end else if (key == KEY_0 && speed_q != SPD_MAX) begin
              speed_q <= speed_q + speed_t'(1);
            end else if (key == KEY_2 && speed_q != SPD_MIN) begin
              speed_q <= speed_q - speed_t'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_rec_start  = rec_start_q;
  assign o_rec_pause  = rec_pause_q;
  assign o_rec_stop   = rec_stop_q;
  assign o_play_start = play_start_q;
  assign o_play_pause = play_pause_q;
  assign o_play_stop  = play_stop_q;
  assign o_recording  = (state_q == REC);
  assign o_playing    = (state_q == PLAY);
  assign o_speed_idx  = speed_q;
  assign o_rec_len    = rec_len_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_audio_mode_ctrl.sv
// tb/tb_audio_mode_ctrl.sv - self-checking bench for audio_mode_ctrl
module tb_audio_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        k0 = 1'b0, k1 = 1'b0, k2 = 1'b0, sw = 1'b0;
  logic [19:0] addr = '0;
  logic        full = 1'b0, done = 1'b0;
  logic        rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop;
  logic        recording, playing;
  logic [3:0]  speed_idx;
  logic [19:0] rec_len;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outcome of one key/level event
  int          m_st  = 0;
  int          m_spd = 0;
  logic [19:0] m_len = '0;
  logic        m_sw  = 1'b0;

  audio_mode_ctrl #(.ADDR_W(20), .MAX_SPEED(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_key_0(k0), .i_key_1(k1), .i_key_2(k2), .i_sw_0(sw),
    .i_rec_addr(addr), .i_rec_full(full), .i_play_done(done),
    .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
    .o_play_start(play_start), .o_play_pause(play_pause), .o_play_stop(play_stop),
    .o_recording(recording), .o_playing(playing), .o_speed_idx(speed_idx),
    .o_rec_len(rec_len), .o_state(state));

  always #5 clk = ~clk;

  wire [5:0] pulses = {play_stop, play_pause, play_start, rec_stop, rec_pause, rec_start};

  task automatic model_step(input bit a0, input bit a1, input bit a2, input bit fl, input bit dn,
                            input bit tg, input logic [19:0] ad, output logic [5:0] exp);
    int  key;
    bit  in_rec, in_play;
    exp     = '0;
    m_sw    = m_sw ^ tg;
    in_rec  = (m_st == 1 || m_st == 2);
    in_play = (m_st == 3 || m_st == 4);
    key     = a1 ? 1 : a0 ? 0 : a2 ? 2 : -1;
    if (in_rec) begin
      if (tg || (m_st == 1 && fl) || key == 0) begin
        exp[2] = 1'b1; m_st = 0; m_len = ad;
      end else if (key == 1) begin
        if (m_st == 1) begin exp[1] = 1'b1; m_st = 2; end
        else begin exp[0] = 1'b1; m_st = 1; end
      end
    end else if (in_play) begin
      if (tg || dn || (m_st == 3 && key == 0)) begin
        exp[5] = 1'b1; m_st = 0;
      end else if (key == 1) begin
        if (m_st == 3) begin exp[4] = 1'b1; m_st = 4; end
        else begin exp[3] = 1'b1; m_st = 3; end
      end else if (key == 0) m_spd = (m_spd + 1 > 7) ? 7 : m_spd + 1;
      else if (key == 2) m_spd = (m_spd - 1 < -7) ? -7 : m_spd - 1;
    end else begin
      if (key == 1) begin
        if (m_sw) begin exp[3] = 1'b1; m_st = 3; end
        else begin exp[0] = 1'b1; m_st = 1; end
      end else if (m_sw && key == 0) m_spd = (m_spd + 1 > 7) ? 7 : m_spd + 1;
      else if (m_sw && key == 2) m_spd = (m_spd - 1 < -7) ? -7 : m_spd - 1;
    end
  endtask

  // Switch flips at cycle 0, keys rise one cycle later, levels sit in the key-pulse cycle;
  // every action then lands on the third edge.
  task automatic do_event(input bit a0, input bit a1, input bit a2, input bit fl, input bit dn,
                          input bit tg, input logic [19:0] ad);
    logic [5:0] exp;
    model_step(a0, a1, a2, fl, dn, tg, ad, exp);
    @(negedge clk);
    addr = ad;
    if (tg) sw = ~sw;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (pulses !== ((c == 3) ? exp : 6'b0)) begin
        n_fail++;
        $display("FAIL pulses cycle %0d: got %b, expected %b", c, pulses, (c == 3) ? exp : 6'b0);
      end
      if (c == 1) begin k0 = a0; k1 = a1; k2 = a2; end
      if (c == 2) begin full = fl; done = dn; end
      if (c == 3) begin full = 1'b0; done = 1'b0; end
      if (c == 5) begin k0 = 1'b0; k1 = 1'b0; k2 = 1'b0; end
    end
    n_checks += 5;
    if (state !== 3'(m_st)) begin n_fail++; $display("FAIL state: got %0d, expected %0d", state, m_st); end
    if (speed_idx !== 4'(m_spd)) begin n_fail++; $display("FAIL speed: got %h, expected %h", speed_idx, 4'(m_spd)); end
    if (rec_len !== m_len) begin n_fail++; $display("FAIL rec_len: got %h, expected %h", rec_len, m_len); end
    if (recording !== (m_st == 1)) begin n_fail++; $display("FAIL recording: got %b, expected %b", recording, m_st == 1); end
    if (playing !== (m_st == 3)) begin n_fail++; $display("FAIL playing: got %b, expected %b", playing, m_st == 3); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pulses, recording, playing, speed_idx, rec_len, state} !== '0) begin
      n_fail++; $display("FAIL reset_hold: got pulses %b state %0d speed %h len %h", pulses, state, speed_idx, rec_len);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pulses, recording, playing, speed_idx, rec_len, state} !== '0) begin
      n_fail++; $display("FAIL reset_release: got pulses %b state %0d speed %h len %h", pulses, state, speed_idx, rec_len);
    end
  endtask

  task automatic test_record_flow();
    do_event(0, 1, 0, 0, 0, 0, 20'h00010);
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL rec_enter: got %0d, expected 1", state); end
    do_event(0, 1, 0, 0, 0, 0, 20'h00050);
    n_checks++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL rec_pause: got %0d, expected 2", state); end
    do_event(0, 1, 0, 0, 0, 0, 20'h00060);
    do_event(1, 0, 0, 0, 0, 0, 20'h00123);
    n_checks++;
    if (state !== 3'd0 || rec_len !== 20'h00123) begin
      n_fail++; $display("FAIL rec_stop: got state %0d len %h, expected 0 00123", state, rec_len);
    end
  endtask

  task automatic test_play_speed();
    do_event(0, 0, 0, 0, 0, 1, 20'h0);
    repeat (3) do_event(1, 0, 0, 0, 0, 0, 20'h0);
    n_checks++;
    if (speed_idx !== 4'd3) begin n_fail++; $display("FAIL speed_up3: got %h, expected 3", speed_idx); end
    do_event(0, 1, 0, 0, 0, 0, 20'h0);
    do_event(0, 1, 0, 0, 0, 0, 20'h0);
    do_event(0, 0, 1, 0, 0, 0, 20'h0);
    n_checks++;
    if (speed_idx !== 4'd2 || state !== 3'd4) begin
      n_fail++; $display("FAIL speed_down_paused: got speed %h state %0d, expected 2 4", speed_idx, state);
    end
    do_event(0, 1, 0, 0, 0, 0, 20'h0);
    do_event(1, 0, 0, 0, 0, 0, 20'h0);
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL play_stop: got %0d, expected 0", state); end
  endtask

  task automatic test_saturation();
    repeat (10) do_event(1, 0, 0, 0, 0, 0, 20'h0);
    n_checks++;
    if (speed_idx !== 4'h7) begin n_fail++; $display("FAIL sat_high: got %h, expected 7", speed_idx); end
    repeat (16) do_event(0, 0, 1, 0, 0, 0, 20'h0);
    n_checks++;
    if (speed_idx !== 4'h9) begin n_fail++; $display("FAIL sat_low: got %h, expected 9", speed_idx); end
  endtask

  task automatic test_done_priority();
    do_event(0, 1, 0, 0, 0, 0, 20'h0);
    do_event(0, 1, 0, 0, 1, 0, 20'h0);
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL done_prio: got %0d, expected 0", state); end
  endtask

  task automatic test_switch_toggle();
    do_event(0, 0, 0, 0, 0, 1, 20'h0);
    do_event(0, 1, 0, 0, 0, 0, 20'h00200);
    do_event(0, 1, 0, 0, 0, 0, 20'h00300);
    do_event(0, 1, 0, 0, 0, 1, 20'h0ABCD);
    n_checks++;
    if (state !== 3'd0 || rec_len !== 20'h0ABCD) begin
      n_fail++; $display("FAIL sw_stop: got state %0d len %h, expected 0 0abcd", state, rec_len);
    end
    do_event(0, 1, 0, 0, 0, 0, 20'h0);
    n_checks++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL sw_play: got %0d, expected 3", state); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({pulses, recording, playing, speed_idx, rec_len, state} !== '0) begin
      n_fail++; $display("FAIL async_rst: got pulses %b state %0d speed %h len %h", pulses, state, speed_idx, rec_len);
    end
    @(negedge clk);
    rst = 1'b0;
    m_st = 0; m_spd = 0; m_len = '0; m_sw = sw;
    repeat (4) @(negedge clk);
    do_event(1, 1, 0, 0, 0, 0, 20'h0);
    n_checks++;
    if (state !== 3'd3 || speed_idx !== 4'd0) begin
      n_fail++; $display("FAIL key1_over_key0: got state %0d speed %h, expected 3 0", state, speed_idx);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      do_event($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               20'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_record_flow();
    test_play_speed();
    test_saturation();
    test_done_priority();
    test_switch_toggle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
